// File: rtl/uart_defs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_defs                                                            |
// | Shared UART state encoding and default line parameters.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned DEFAULT_BIT_PER_WORD = 7;

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_baud_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | baud_counter                                                         |
// | Per-bit cycle counter; bitTick marks the last cycle of each bit.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module baud_counter #(
  parameter int unsigned CLKS_PER_BIT = uart_defs::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic resetN,
  input  logic run,
  output logic bitTick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Held at zero whenever the bit timer is not running
  always_comb begin
    cnt_d = '0;
    if (run && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bitTick = run && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_transmitter                                                     |
// | Drains words from the TX buffer and sends each as an 8N1 frame.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module uart_transmitter
  import uart_defs::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned BIT_PER_WORD = DEFAULT_BIT_PER_WORD
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  fifoEmpty,
  input  logic [BIT_PER_WORD:0] fifoData,
  output logic                  fifoRead,
  output logic                  txOut,
  output logic                  busy,
  output logic                  txDone
);

  localparam int unsigned IDX_W = (BIT_PER_WORD > 0) ? $clog2(BIT_PER_WORD + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BIT_PER_WORD);

  uart_state_e           state_q, state_d;
  logic [BIT_PER_WORD:0] shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  txOut_q, txOut_d;
  logic                  fifoRead_q, fifoRead_d;
  logic                  txDone_q, txDone_d;

  logic                  baudRun;
  logic                  bitTick;

  assign baudRun = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);

  baud_counter #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .resetN  (resetN),
    .run     (baudRun),
    .bitTick (bitTick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    txOut_d    = txOut_q;
    fifoRead_d = 1'b0;
    txDone_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        txOut_d = 1'b1;
        if (!fifoEmpty) begin
          state_d    = ST_FETCH;
          fifoRead_d = 1'b1;
        end
      end

      ST_FETCH: begin
        state_d = ST_LATCH;
      end

      // Buffer data became valid at the end of FETCH; start bit goes out with the capture
      ST_LATCH: begin
        state_d = ST_START;
        shift_d = fifoData;
        txOut_d = 1'b0;
      end

      ST_START: begin
        idx_d = '0;
        if (bitTick) begin
          state_d = ST_DATA;
          txOut_d = shift_q[0];
        end
      end

      ST_DATA: begin
        if (bitTick) begin
          if (idx_q == IDX_LAST) begin
            state_d = ST_STOP;
            txOut_d = 1'b1;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shift_d = shift_q >> 1;
            txOut_d = shift_d[0];
          end
        end
      end

      ST_STOP: begin
        if (bitTick) begin
          state_d  = ST_IDLE;
          txDone_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        txOut_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      txOut_q    <= 1'b1;
      fifoRead_q <= 1'b0;
      txDone_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      txOut_q    <= txOut_d;
      fifoRead_q <= fifoRead_d;
      txDone_q   <= txDone_d;
    end
  end

  assign txOut    = txOut_q;
  assign fifoRead = fifoRead_q;
  assign txDone   = txDone_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_transmitter.md
# uart_transmitter

Serial transmit stage for the bidirectional UART: drains 8-bit words from the transmit circular buffer and sends each as one 8N1 frame on `txOut`. The block sits directly downstream of the buffer. `fifoRead` drives the buffer's `enableOut`, `fifoEmpty` comes from its `empty`, and `fifoData` comes from its registered `dataOut`. One word is fetched per frame; the line idles high.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200). Must be ≥ 2.
- `BIT_PER_WORD`, 7: word width minus one, matching the buffer parameter.
- `clk` in 1: system clock, rising edge.
- `resetN` in 1: one clock; reset is asynchronous and active-low.
- `fifoEmpty` in 1: buffer empty flag.
- `fifoData` in `BIT_PER_WORD+1`: buffer read data. Valid from the edge after the `fifoRead` cycle.
- `fifoRead` out 1: registered one-cycle read strobe to the buffer.
- `txOut` out 1: serial line, idle high.
- `busy` out 1: high in every state except IDLE.
- `txDone` out 1: one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, FETCH, LATCH, START, DATA, STOP.
- IDLE → FETCH: when `fifoEmpty`=0 at a rising edge. `fifoRead` is high for exactly the FETCH cycle.
- FETCH → LATCH: unconditional. The buffer updates `dataOut` at this edge.
- LATCH → START: unconditional. `fifoData` is captured into the shift register at this edge.
- START: `txOut`=0 for `CLKS_PER_BIT` cycles.
- DATA: bits sent LSB first. Each bit lasts `CLKS_PER_BIT` cycles. Bit index runs 0..`BIT_PER_WORD`, then STOP.
- STOP: `txOut`=1 for `CLKS_PER_BIT` cycles. At its last edge the block moves to IDLE and asserts `txDone` for one cycle.
- `fifoEmpty` is ignored outside IDLE. A word arriving mid-frame waits until IDLE.
- The baud counter is `$clog2(CLKS_PER_BIT)` bits wide. It runs 0..`CLKS_PER_BIT`-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE, FETCH and LATCH.
- The bit index is `$clog2(BIT_PER_WORD+1)` bits wide and is cleared in START.
- `txOut` is driven from a register, so it is glitch-free.
- Reset values: state IDLE, `txOut`=1, `fifoRead`=0, `busy`=0, `txDone`=0, all counters 0.
- Reset mid-frame: `txOut` returns high immediately (asynchronous). The in-flight word is discarded and not re-read. After release the block is in IDLE.
- Reset asserted during FETCH: `fifoRead` drops immediately. Whether the buffer consumed the word is the buffer's concern.

## Timing
- Latency: if `fifoEmpty`=0 is sampled at edge E0, then:
  - `fifoRead` is high E0..E1.
  - Capture happens at E2.
  - The start bit begins at E2.
- Frame length: `10·CLKS_PER_BIT` cycles from the start-bit edge to the `txDone` edge.
- Back-to-back: if the stop bit ends at edge S and the buffer is non-empty, the next start bit begins at S+3 (IDLE, FETCH, LATCH). The line holds high for those 3 extra cycles.
- `fifoRead` is never asserted while `fifoEmpty`=1 at the sampling edge. It is never asserted twice per frame.
- `busy` rises at E0 and falls at the `txDone` edge.

## Structure
- Shared package `uart_defs`: state encoding, default `CLKS_PER_BIT`, default `BIT_PER_WORD`. The receiver reuses these.
- Sub-module `baud_counter`: parameterised by `CLKS_PER_BIT`. Inputs `clk`, `resetN`, `run`; output `bitTick`, high on the last cycle of each bit. The receiver shares it.
- Top level: FSM, shift register, bit index.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `BIT_PER_WORD`=7.
- Reset with `fifoEmpty`=1, held 200 cycles → `txOut`=1, `fifoRead`=0, `busy`=0, `txDone`=0 throughout.
- Single word 0xA5 → one `fifoRead` pulse 1 cycle wide. `txOut` sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles, start at E2. `txDone` pulses 40 cycles after start.
- Words 0x00 then 0xFF queued → two `fifoRead` pulses. Frames 0,0×8,1 and 0,1×8,1. The second start bit comes exactly 3 cycles after the first stop bit ends.
- `fifoEmpty` falls at data bit 3 of an active frame → no `fifoRead` until after `txDone`. The next frame starts 3 cycles after the stop bit ends.
- `resetN` pulsed low during data bit 4 of 0x0F → `txOut`=1 within the same cycle. After release with `fifoEmpty`=1: no `fifoRead`, `busy`=0, no `txDone`.
- Buffer model with 16 entries filled with 0x30..0x3F → 16 frames decoded by the bench UART receiver match in order. Exactly 16 `fifoRead` pulses, none while the buffer is empty.
